window_7x7_gen: RTL and testbench
=================================

Name: window_7x7_gen

Overview:
- Streaming 7x7 neighbourhood generator. It feeds the centre-intensity (CI) binarizer and other MRELBP patch consumers.
- Accepts a raster-order pixel stream (one pixel per beat) and buffers the six previous image lines in on-chip line buffers.
- Emits a complete 7x7 window as a flattened bus plus a valid strobe for every position whose window lies fully inside the image. Border positions are not padded.

Parameters:
- WIDTH, 8, pixel bit width.
- IMG_WIDTH, 64, pixels per line (>=7).
- IMG_HEIGHT, 64, lines per frame (>=7).

Ports:
- i_clk  in  1  single clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input pixel beat is valid this cycle.
- i_sof  in  1  start of frame; qualified by i_valid; marks the pixel at row 0, column 0.
- i_pixel  in  WIDTH  input pixel, raster order.
- o_valid  out  1  o_window holds a full in-image window.
- o_window  out  49*WIDTH  window element (r,c), r,c in 0..6, sits at bits [(r*7+c)*WIDTH +: WIDTH].
  - r=0 is the oldest (top) line; c=0 is the leftmost (oldest) column.
  - The centre pixel is (3,3), bits [24*WIDTH +: WIDTH].
- o_eof  out  1  asserted with the last o_valid of a frame.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - col_cnt, row_cnt, o_valid, o_eof and all 49 window registers go to 0.
  - Line-buffer RAM contents are not cleared. They are don't-care until overwritten.
- Counters:
  - col_cnt is $clog2(IMG_WIDTH) bits; row_cnt is $clog2(IMG_HEIGHT) bits.
  - Both advance only on an accepted beat (i_valid=1).
  - col_cnt wraps from IMG_WIDTH-1 to 0 and increments row_cnt.
  - row_cnt wraps from IMG_HEIGHT-1 to 0. The next frame then begins with no i_sof required.
- i_sof:
  - With i_valid=1, the beat is treated as pixel (0,0) regardless of the counters. Counters restart from that beat.
  - A mid-frame i_sof aborts the current frame. No o_eof is produced for the aborted frame.
  - i_sof with i_valid=0 is ignored.
- Line buffers:
  - Six cascaded buffers of depth IMG_WIDTH, addressed by col_cnt.
  - On an accepted beat, buffer k is read at col_cnt and written with the output of buffer k-1; buffer 0 is written with i_pixel. This is a read-before-write per address.
  - The resulting column vector, top to bottom, is: {lb5, lb4, lb3, lb2, lb1, lb0, i_pixel}.
- Window:
  - On an accepted beat, every row shifts left by one column: (r,c) <= (r,c+1).
  - Column 6 loads the new column vector, with row 6 = i_pixel.
  - With i_valid=0, the window, counters and line buffers hold.
- Output timing:
  - o_valid is registered. It is 1 in the cycle after accepting a beat at (row_cnt, col_cnt) with row_cnt>=6 and col_cnt>=6; otherwise it is 0.
  - o_valid is a single-cycle strobe per qualifying beat and is never held across idle cycles.
  - Latency from the input beat to o_valid is 1 cycle.
  - The window then covers image rows row_cnt-6..row_cnt and columns col_cnt-6..col_cnt.
- o_eof: 1 together with o_valid for the beat at (IMG_HEIGHT-1, IMG_WIDTH-1); 0 otherwise.
- Count: exactly (IMG_WIDTH-6)*(IMG_HEIGHT-6) o_valid strobes per complete frame.
- Line wrap: the window registers carry stale columns from the previous line during col_cnt 0..5. o_valid suppresses them, so no flush is needed.
- No backpressure. A downstream consumer must accept one window per cycle.
- Arithmetic: counters only; no pixel arithmetic; all values unsigned.

Test Plan:
- Basic fill (IMG_WIDTH=IMG_HEIGHT=8), i_pixel=row*16+col, continuous i_valid, i_sof on the first beat:
  - First o_valid one cycle after the 55th beat.
  - Window(0,0)=0x00, (3,3)=0x33, (6,6)=0x66.
  - Exactly 4 strobes, centres 0x33, 0x34, 0x43, 0x44.
  - o_eof with the 4th strobe only.
- Stall insensitivity: same frame with i_valid randomly deasserted ~40% of cycles -> identical sequence of o_window values; o_valid never asserted in a cycle not preceded by an accepted beat.
- Back-to-back frames: two 8x8 frames, the second with pixel = 0x80+row*16+col and no gap, i_sof on the first beat only -> second frame first centre 0xB3, 4 strobes, o_eof twice in total.
- Mid-frame i_sof: restart with i_sof at frame-1 pixel (4,2) -> counters restart; no o_eof for the aborted frame; the next full frame yields 4 correct windows (centres 0x33, 0x34, 0x43, 0x44).
- Reset mid-frame: assert i_rst for 1 cycle after 60 beats ->
  - o_valid and o_eof read 0 the cycle after the reset edge.
  - A fresh frame then produces the first o_valid after the 55th new beat, with centre 0x33.
- Parameter sweep IMG_WIDTH=7, IMG_HEIGHT=9 -> exactly 3 strobes per frame, centres (3,3), (4,3), (5,3).

Source files
------------

// File: rtl/window_7x7_gen.sv
// window_7x7_gen: streaming 7x7 neighbourhood generator built on six cascaded line buffers.
module window_7x7_gen #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [WIDTH-1:0]      i_pixel,
  output logic                  o_valid,
  output logic [49*WIDTH-1:0]   o_window,
  output logic                  o_eof
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col_cnt, col_eff;
  logic [RW-1:0] row_cnt, row_eff;
  logic col_last, row_last;
  logic [WIDTH-1:0] lb [6][IMG_WIDTH];
  logic [WIDTH-1:0] win [7][7];
  logic [WIDTH-1:0] col_vec [7];
  // a start-of-frame beat is position (0,0) whatever the counters say
  assign col_eff  = i_sof ? '0 : col_cnt;
  assign row_eff  = i_sof ? '0 : row_cnt;
  assign col_last = col_eff == CW'(IMG_WIDTH - 1);
  assign row_last = row_eff == RW'(IMG_HEIGHT - 1);
  assign col_vec[6] = i_pixel;
  for (genvar r = 0; r < 6; r++) begin : g_col
    assign col_vec[r] = lb[5-r][col_eff];
  end
  for (genvar r = 0; r < 7; r++) begin : g_row
    for (genvar c = 0; c < 7; c++) begin : g_elem
      assign o_window[(r*7+c)*WIDTH +: WIDTH] = win[r][c];
    end
  end
  always_ff @(posedge i_clk)
    if (i_valid) begin
      lb[0][col_eff] <= i_pixel;
      for (int k = 1; k < 6; k++) lb[k][col_eff] <= lb[k-1][col_eff];
    end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++) win[r][c] <= '0;
    end else begin
      o_valid <= i_valid && row_eff >= RW'(6) && col_eff >= CW'(6);
      o_eof   <= i_valid && row_last && col_last;
      if (i_valid) begin
        col_cnt <= col_last ? '0 : col_eff + 1'b1;
        row_cnt <= !col_last ? row_eff : row_last ? '0 : row_eff + 1'b1;
        for (int r = 0; r < 7; r++) begin
          for (int c = 0; c < 6; c++) win[r][c] <= win[r][c+1];
          win[r][6] <= col_vec[r];
        end
      end
    end
endmodule

// File: tb/tb_window_7x7_gen.sv
// tb_window_7x7_gen: checks an 8x8 and a 7x9 instance against an image-array model of the window stream.
module tb_window_7x7_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [2];
  logic is [2];
  logic [7:0] ip [2];
  logic ov [2];
  logic oe [2];
  logic [391:0] ow [2];
  int vectors = 0, miscompares = 0;
  int idx [2], acc [2], strobes [2], eofs [2], first_at [2];
  logic ev [2];
  logic ee [2];
  logic [391:0] ew [2];
  logic [391:0] fw [2];
  logic [7:0] img [2][9][8];
  logic [7:0] cen [2][16];

  always #5 clk = ~clk;

  window_7x7_gen #(.WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[0]), .i_sof(is[0]), .i_pixel(ip[0]),
    .o_valid(ov[0]), .o_window(ow[0]), .o_eof(oe[0]));
  window_7x7_gen #(.WIDTH(8), .IMG_WIDTH(7), .IMG_HEIGHT(9)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[1]), .i_sof(is[1]), .i_pixel(ip[1]),
    .o_valid(ov[1]), .o_window(ow[1]), .o_eof(oe[1]));

  function automatic int wd(input int d); return d ? 7 : 8; endfunction
  function automatic int ht(input int d); return d ? 9 : 8; endfunction

  // each accepted beat lands at (idx/W, idx%W) of an image array; a full window is read straight out of it
  task automatic model();
    for (int d = 0; d < 2; d++) begin
      int r, c;
      ev[d] = 1'b0;
      ee[d] = 1'b0;
      if (rst) idx[d] = 0;
      else if (iv[d]) begin
        if (is[d]) idx[d] = 0;
        r = idx[d] / wd(d);
        c = idx[d] % wd(d);
        img[d][r][c] = ip[d];
        acc[d]++;
        if (r >= 6 && c >= 6) begin
          ev[d] = 1'b1;
          ee[d] = (r == ht(d) - 1) && (c == wd(d) - 1);
          for (int rr = 0; rr < 7; rr++)
            for (int cc = 0; cc < 7; cc++)
              ew[d][(rr*7+cc)*8 +: 8] = img[d][r-6+rr][c-6+cc];
        end
        idx[d] = (idx[d] + 1) % (wd(d) * ht(d));
      end
    end
  endtask

  task automatic check();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (ov[d] !== ev[d] || oe[d] !== ee[d] || (ev[d] && ow[d] !== ew[d])) begin
        miscompares++;
        $display("FAIL cycle dut%0d t=%0t valid %b want %b eof %b want %b window %h want %h",
                 d, $time, ov[d], ev[d], oe[d], ee[d], ow[d], ew[d]);
      end
      if (ov[d] === 1'b1) begin
        if (strobes[d] == 0) begin
          first_at[d] = acc[d];
          fw[d] = ow[d];
        end
        if (strobes[d] < 16) cen[d][strobes[d]] = ow[d][24*8 +: 8];
        strobes[d]++;
        if (oe[d] === 1'b1) eofs[d]++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    check();
  endtask

  task automatic pin(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0;
      strobes[d] = 0;
      eofs[d] = 0;
      first_at[d] = -1;
    end
  endtask

  task automatic idle(input int n);
    iv[0] = 1'b0; iv[1] = 1'b0; is[0] = 1'b0; is[1] = 1'b0;
    repeat (n) cyc();
  endtask

  // n beats of pixel base+row*16+col; stall is the percentage of idle cycles, which carry junk pixel/sof
  task automatic beats(input int d, input int n, input int base, input bit sof, input int stall);
    int k = 0;
    while (k < n) begin
      if ($urandom_range(99) < stall) begin
        iv[d] = 1'b0;
        is[d] = 1'($urandom_range(1));
        ip[d] = 8'($urandom);
      end else begin
        iv[d] = 1'b1;
        is[d] = sof && k == 0;
        ip[d] = 8'(base + (k / wd(d)) * 16 + k % wd(d));
        k++;
      end
      cyc();
    end
    iv[d] = 1'b0;
    is[d] = 1'b0;
  endtask

  task automatic pin_centres8(input string tag);
    pin({tag, "_strobes"}, strobes[0], 4);
    pin({tag, "_eofs"}, eofs[0], 1);
    pin({tag, "_c0"}, cen[0][0], 'h33);
    pin({tag, "_c1"}, cen[0][1], 'h34);
    pin({tag, "_c2"}, cen[0][2], 'h43);
    pin({tag, "_c3"}, cen[0][3], 'h44);
  endtask

  initial begin
    iv = '{1'b0, 1'b0};
    is = '{1'b0, 1'b0};
    ip = '{8'h00, 8'h00};
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    pin("rst_valid", int'(ov[0]), 0);
    pin("rst_eof", int'(oe[0]), 0);
    pin("rst_window_nonzero", int'(ow[0] != '0), 0);

    clr();
    beats(0, 64, 0, 1'b1, 0);
    idle(3);
    pin("fill_first_at", first_at[0], 55);
    pin("fill_w00", fw[0][0 +: 8], 'h00);
    pin("fill_w33", fw[0][24*8 +: 8], 'h33);
    pin("fill_w66", fw[0][48*8 +: 8], 'h66);
    pin_centres8("fill");

    clr();
    beats(0, 64, 0, 1'b1, 40);
    idle(3);
    pin("stall_w00", fw[0][0 +: 8], 'h00);
    pin("stall_w66", fw[0][48*8 +: 8], 'h66);
    pin_centres8("stall");

    clr();
    beats(0, 64, 0, 1'b1, 0);
    beats(0, 64, 'h80, 1'b0, 0);
    idle(3);
    pin("b2b_strobes", strobes[0], 8);
    pin("b2b_eofs", eofs[0], 2);
    pin("b2b_first2", cen[0][4], 'hB3);
    pin("b2b_last2", cen[0][7], 'hC4);

    clr();
    beats(0, 34, 'h80, 1'b1, 0);
    beats(0, 64, 0, 1'b1, 0);
    idle(3);
    pin_centres8("abort");

    clr();
    beats(0, 60, 0, 1'b1, 0);
    rst = 1'b1;
    cyc();
    pin("mid_rst_valid", int'(ov[0]), 0);
    pin("mid_rst_eof", int'(oe[0]), 0);
    pin("mid_rst_window_nonzero", int'(ow[0] != '0), 0);
    rst = 1'b0;
    clr();
    beats(0, 64, 0, 1'b1, 0);
    idle(3);
    pin("after_rst_first_at", first_at[0], 55);
    pin_centres8("after_rst");

    clr();
    beats(1, 63, 0, 1'b1, 30);
    idle(3);
    pin("sweep_strobes", strobes[1], 3);
    pin("sweep_eofs", eofs[1], 1);
    pin("sweep_c0", cen[1][0], 'h33);
    pin("sweep_c1", cen[1][1], 'h43);
    pin("sweep_c2", cen[1][2], 'h53);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
